// File: rtl/reaction_test_sequencer_pkg.sv
// Shared definitions for the reaction test sequencer: state encodings,
// error codes and the LFSR seed/taps used for the random pre-GO delay.
package reaction_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_GO   = 3'd3,
    ST_HOLD = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_EARLY   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting form of taps 16,14,13,11: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/reaction_test_sequencer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; the non-zero seed on reset keeps it
// out of the all-zero lock-up state.
module lfsr16
  import reaction_test_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= LFSR_SEED;
    end else begin
      value_q <= lfsrStep(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/reaction_test_sequencer.sv
// Reaction test sequencer: random delay, timer run, freeze on press, and
// early/timeout/abort reporting. All outputs are registered from next state.
module reaction_test_sequencer
  import reaction_test_sequencer_pkg::*;
#(
  parameter logic [15:0] MIN_DELAY_MS = 16'd1000,
  parameter logic [15:0] RAND_MASK    = 16'h07FF,
  parameter logic [15:0] TIMEOUT_MS   = 16'd2781
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iButton,
  input  logic [15:0] iTimer_msec,
  output logic        oTimerRst,
  output logic        oEnableDisplay,
  output logic        oFreezeDisplay,
  output logic [1:0]  oErrorCodes,
  output logic [15:0] oDelay_msec,
  output logic [2:0]  oState
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_ARM  = ST_ARM;
  localparam logic [2:0] S_WAIT = ST_WAIT;
  localparam logic [2:0] S_GO   = ST_GO;
  localparam logic [2:0] S_HOLD = ST_HOLD;
  localparam logic [2:0] S_ERR  = ST_ERR;

  logic [15:0] lfsrValue;

  logic [2:0]  state_q,    state_d;
  logic [1:0]  err_q,      err_d;
  logic [15:0] delay_q,    delay_d;
  logic        timerRst_q, timerRst_d;
  logic        enable_q,   enable_d;
  logic        freeze_q,   freeze_d;
  logic        timerRstPrev_q;
  logic        cmpEn;

  lfsr16 uLfsr (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .value_o (lfsrValue)
  );

  // The timer count is stale while reset is requested and one cycle after
  assign cmpEn = !timerRst_q && !timerRstPrev_q;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    delay_d = delay_q;
    case (state_q)
      S_IDLE: begin
        err_d = ERR_NONE;
        if (iStart) begin
          state_d = S_ARM;
          delay_d = MIN_DELAY_MS + (lfsrValue & RAND_MASK);
        end
      end
      S_ARM: state_d = S_WAIT;
      S_WAIT: begin
        if (iButton) begin
          state_d = S_ERR;
          err_d   = ERR_EARLY;
        end else if (cmpEn && (iTimer_msec >= delay_q)) begin
          state_d = S_GO;
        end
      end
      S_GO: begin
        if (iButton) begin
          state_d = S_HOLD;
        end else if (cmpEn && (iTimer_msec >= TIMEOUT_MS)) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end else if (iStart) begin
          state_d = S_ERR;
          err_d   = ERR_ABORT;
        end
      end
      S_HOLD, S_ERR: begin
        if (iStart) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = ERR_NONE;
      end
    endcase

    timerRst_d = (state_d == S_IDLE) || (state_d == S_ARM) ||
                 ((state_d == S_GO) && (state_q != S_GO));
    enable_d   = (state_d == S_GO) || (state_d == S_HOLD) || (state_d == S_ERR);
    freeze_d   = (state_d == S_HOLD) || (state_d == S_ERR);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q        <= S_IDLE;
      err_q          <= ERR_NONE;
      delay_q        <= '0;
      timerRst_q     <= 1'b1;
      timerRstPrev_q <= 1'b1;
      enable_q       <= 1'b0;
      freeze_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_q          <= err_d;
      delay_q        <= delay_d;
      timerRst_q     <= timerRst_d;
      timerRstPrev_q <= timerRst_q;
      enable_q       <= enable_d;
      freeze_q       <= freeze_d;
    end
  end

  assign oTimerRst      = timerRst_q;
  assign oEnableDisplay = enable_q;
  assign oFreezeDisplay = freeze_q;
  assign oErrorCodes    = err_q;
  assign oDelay_msec    = delay_q;
  assign oState         = state_q;

endmodule

// File: tb/tb_reaction_test_sequencer.sv
// Directed bench for the reaction test sequencer with a bench-side timer
// that either ramps (cleared by oTimerRst) or is forced to chosen values.
module tb_reaction_test_sequencer;

  logic        iClk;
  logic        iRst;
  logic        iStart;
  logic        iButton;
  logic [15:0] iTimer_msec;
  logic        oTimerRst;
  logic        oEnableDisplay;
  logic        oFreezeDisplay;
  logic [1:0]  oErrorCodes;
  logic [15:0] oDelay_msec;
  logic [2:0]  oState;

  logic        rampEn = 1'b0;
  logic [15:0] rampTmr = 16'd0;
  logic [15:0] forcedTmr = 16'd0;

  int assertCount = 0;
  int failCount = 0;

  // Status word: {state, timerRst, enable, freeze, errorCodes}
  localparam logic [7:0] ST_IDLE_EXP  = {3'd0, 1'b1, 1'b0, 1'b0, 2'b00};
  localparam logic [7:0] ST_ARM_EXP   = {3'd1, 1'b1, 1'b0, 1'b0, 2'b00};
  localparam logic [7:0] ST_WAIT_EXP  = {3'd2, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [7:0] ST_GO0_EXP   = {3'd3, 1'b1, 1'b1, 1'b0, 2'b00};
  localparam logic [7:0] ST_GO_EXP    = {3'd3, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [7:0] ST_HOLD_EXP  = {3'd4, 1'b0, 1'b1, 1'b1, 2'b00};
  localparam logic [7:0] ST_EARLY_EXP = {3'd5, 1'b0, 1'b1, 1'b1, 2'b01};
  localparam logic [7:0] ST_TOUT_EXP  = {3'd5, 1'b0, 1'b1, 1'b1, 2'b10};
  localparam logic [7:0] ST_ABORT_EXP = {3'd5, 1'b0, 1'b1, 1'b1, 2'b11};

  // LFSR 0xACE1 after five right-shift steps is 0x1567; 1000 + 0x567 = 2383
  localparam logic [15:0] DELAY_AFTER_5 = 16'd2383;

  reaction_test_sequencer dut (
    .iClk           (iClk),
    .iRst           (iRst),
    .iStart         (iStart),
    .iButton        (iButton),
    .iTimer_msec    (iTimer_msec),
    .oTimerRst      (oTimerRst),
    .oEnableDisplay (oEnableDisplay),
    .oFreezeDisplay (oFreezeDisplay),
    .oErrorCodes    (oErrorCodes),
    .oDelay_msec    (oDelay_msec),
    .oState         (oState)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    if (oTimerRst) rampTmr <= 16'd0;
    else           rampTmr <= rampTmr + 16'd1;
  end

  assign iTimer_msec = rampEn ? rampTmr : forcedTmr;

  function automatic logic [7:0] status();
    return {oState, oTimerRst, oEnableDisplay, oFreezeDisplay, oErrorCodes};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic pulseButton();
    iButton = 1'b1;
    tick();
    iButton = 1'b0;
  endtask

  // Leaves the DUT in the first GO cycle with the forced timer back at 0
  task automatic enterGo();
    forcedTmr = 16'd0;
    pulseStart();
    tick();
    tick();
    forcedTmr = 16'hFFFF;
    tick();
    forcedTmr = 16'd0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iStart = 1'b0; iButton = 1'b0; rampEn = 1'b0; forcedTmr = 16'd0;
    repeat (3) tick();
    assertCount++;
    if (status() !== ST_IDLE_EXP) begin
      failCount++;
      $display("[TB] FAIL reset_status: got %b expected %b", status(), ST_IDLE_EXP);
    end
    iRst = 1'b0;
    repeat (20) tick();
    assertCount++;
    if (status() !== ST_IDLE_EXP) begin
      failCount++;
      $display("[TB] FAIL idle20_status: got %b expected %b", status(), ST_IDLE_EXP);
    end
    assertCount++;
    if (oDelay_msec !== 16'd0) begin
      failCount++;
      $display("[TB] FAIL idle20_delay: got %0d expected 0", oDelay_msec);
    end
  endtask

  task automatic test_hold();
    int cycles;
    rampEn = 1'b1;
    pulseStart();
    assertCount++;
    if (status() !== ST_ARM_EXP) begin
      failCount++;
      $display("[TB] FAIL hold_arm: got %b expected %b", status(), ST_ARM_EXP);
    end
    tick();
    assertCount++;
    if (status() !== ST_WAIT_EXP) begin
      failCount++;
      $display("[TB] FAIL hold_wait: got %b expected %b", status(), ST_WAIT_EXP);
    end
    cycles = 0;
    while (oState !== 3'd3 && cycles < 4000) begin
      tick();
      cycles++;
    end
    assertCount++;
    if (status() !== ST_GO0_EXP) begin
      failCount++;
      $display("[TB] FAIL hold_go_entry: got %b expected %b after %0d cycles", status(), ST_GO0_EXP, cycles);
    end
    cycles = 0;
    while (iTimer_msec !== 16'd350 && cycles < 1000) begin
      tick();
      cycles++;
    end
    assertCount++;
    if (status() !== ST_GO_EXP || iTimer_msec !== 16'd350) begin
      failCount++;
      $display("[TB] FAIL hold_go_run: got %b timer %0d expected %b timer 350", status(), iTimer_msec, ST_GO_EXP);
    end
    pulseButton();
    assertCount++;
    if (status() !== ST_HOLD_EXP) begin
      failCount++;
      $display("[TB] FAIL hold_freeze: got %b expected %b", status(), ST_HOLD_EXP);
    end
    pulseButton();
    assertCount++;
    if (status() !== ST_HOLD_EXP) begin
      failCount++;
      $display("[TB] FAIL hold_button_ignored: got %b expected %b", status(), ST_HOLD_EXP);
    end
    pulseStart();
    assertCount++;
    if (status() !== ST_IDLE_EXP) begin
      failCount++;
      $display("[TB] FAIL hold_clear: got %b expected %b", status(), ST_IDLE_EXP);
    end
    rampEn = 1'b0;
  endtask

  task automatic test_early();
    forcedTmr = 16'd200;
    pulseStart();
    tick();
    pulseStart();
    assertCount++;
    if (status() !== ST_WAIT_EXP) begin
      failCount++;
      $display("[TB] FAIL early_start_ignored: got %b expected %b", status(), ST_WAIT_EXP);
    end
    pulseButton();
    assertCount++;
    if (status() !== ST_EARLY_EXP) begin
      failCount++;
      $display("[TB] FAIL early_err: got %b expected %b", status(), ST_EARLY_EXP);
    end
    pulseButton();
    assertCount++;
    if (status() !== ST_EARLY_EXP) begin
      failCount++;
      $display("[TB] FAIL early_button_ignored: got %b expected %b", status(), ST_EARLY_EXP);
    end
    pulseStart();
    assertCount++;
    if (status() !== ST_IDLE_EXP) begin
      failCount++;
      $display("[TB] FAIL early_clear: got %b expected %b", status(), ST_IDLE_EXP);
    end
  endtask

  task automatic test_stale();
    forcedTmr = 16'd0;
    pulseStart();
    tick();
    forcedTmr = 16'hFFFF;
    tick();
    assertCount++;
    if (status() !== ST_WAIT_EXP) begin
      failCount++;
      $display("[TB] FAIL stale_blank_wait: got %b expected %b", status(), ST_WAIT_EXP);
    end
    tick();
    assertCount++;
    if (status() !== ST_GO0_EXP) begin
      failCount++;
      $display("[TB] FAIL stale_then_go: got %b expected %b", status(), ST_GO0_EXP);
    end
    forcedTmr = 16'd0;
    tick();
    assertCount++;
    if (status() !== ST_GO_EXP) begin
      failCount++;
      $display("[TB] FAIL go_rst_one_cycle: got %b expected %b", status(), ST_GO_EXP);
    end
    pulseStart();
    assertCount++;
    if (status() !== ST_ABORT_EXP) begin
      failCount++;
      $display("[TB] FAIL abort_err: got %b expected %b", status(), ST_ABORT_EXP);
    end
    pulseStart();
    // Stale count and press together right after ARM: press wins, no GO
    pulseStart();
    tick();
    forcedTmr = 16'hFFFF;
    pulseButton();
    assertCount++;
    if (status() !== ST_EARLY_EXP) begin
      failCount++;
      $display("[TB] FAIL stale_button: got %b expected %b", status(), ST_EARLY_EXP);
    end
    pulseStart();
    forcedTmr = 16'd0;
    pulseStart();
    tick();
    tick();
    forcedTmr = 16'hFFFF;
    pulseButton();
    assertCount++;
    if (status() !== ST_EARLY_EXP) begin
      failCount++;
      $display("[TB] FAIL wait_button_priority: got %b expected %b", status(), ST_EARLY_EXP);
    end
    pulseStart();
    forcedTmr = 16'd0;
  endtask

  task automatic test_timeout();
    enterGo();
    forcedTmr = 16'd2781;
    tick();
    tick();
    assertCount++;
    if (status() !== ST_GO_EXP) begin
      failCount++;
      $display("[TB] FAIL timeout_blanked: got %b expected %b", status(), ST_GO_EXP);
    end
    forcedTmr = 16'd2780;
    tick();
    assertCount++;
    if (status() !== ST_GO_EXP) begin
      failCount++;
      $display("[TB] FAIL timeout_below: got %b expected %b", status(), ST_GO_EXP);
    end
    forcedTmr = 16'd2781;
    tick();
    assertCount++;
    if (status() !== ST_TOUT_EXP) begin
      failCount++;
      $display("[TB] FAIL timeout_err: got %b expected %b", status(), ST_TOUT_EXP);
    end
    pulseStart();
    assertCount++;
    if (status() !== ST_IDLE_EXP) begin
      failCount++;
      $display("[TB] FAIL timeout_clear: got %b expected %b", status(), ST_IDLE_EXP);
    end
  endtask

  task automatic test_go_priority();
    enterGo();
    tick();
    tick();
    forcedTmr = 16'd2781;
    pulseButton();
    assertCount++;
    if (status() !== ST_HOLD_EXP) begin
      failCount++;
      $display("[TB] FAIL button_beats_timeout: got %b expected %b", status(), ST_HOLD_EXP);
    end
    pulseStart();
    enterGo();
    tick();
    tick();
    forcedTmr = 16'd2781;
    pulseStart();
    assertCount++;
    if (status() !== ST_TOUT_EXP) begin
      failCount++;
      $display("[TB] FAIL timeout_beats_start: got %b expected %b", status(), ST_TOUT_EXP);
    end
    pulseStart();
    forcedTmr = 16'd0;
  endtask

  task automatic test_reset_mid_go();
    enterGo();
    tick();
    iRst = 1'b1;
    #1;
    assertCount++;
    if (status() !== ST_IDLE_EXP) begin
      failCount++;
      $display("[TB] FAIL async_reset_status: got %b expected %b", status(), ST_IDLE_EXP);
    end
    assertCount++;
    if (oDelay_msec !== 16'd0) begin
      failCount++;
      $display("[TB] FAIL async_reset_delay: got %0d expected 0", oDelay_msec);
    end
    tick();
    iRst = 1'b0;
  endtask

  task automatic test_lfsr_delay();
    repeat (5) tick();
    pulseStart();
    assertCount++;
    if (status() !== ST_ARM_EXP) begin
      failCount++;
      $display("[TB] FAIL lfsr_arm: got %b expected %b", status(), ST_ARM_EXP);
    end
    assertCount++;
    if (oDelay_msec !== DELAY_AFTER_5) begin
      failCount++;
      $display("[TB] FAIL lfsr_delay: got %0d expected %0d", oDelay_msec, DELAY_AFTER_5);
    end
    assertCount++;
    if (oDelay_msec < 16'd1000 || oDelay_msec > 16'd3047) begin
      failCount++;
      $display("[TB] FAIL lfsr_delay_range: got %0d expected 1000..3047", oDelay_msec);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_early();
    test_stale();
    test_timeout();
    test_go_priority();
    test_reset_mid_go();
    test_lfsr_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
